protocol_device_fsm: RTL and testbench

USB-style function-side protocol engine: the responder to the host transaction FSM on the same link. It sits between the packet decoder (pkt_in/pkt_received/crc_correct) and the packet encoder (pkt_out/encode/kill/pkt_sent). It accepts IN/OUT tokens addressed to its endpoint, receives OUT data and handshakes it, and sources IN data with retry on NAK or timeout. Per-transaction success and failure pulses go to the device core.

---
 rtl/protocol_device_fsm.sv | 273 +++++++++++++++++++++++++++
 tb/tb_protocol_device_fsm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/protocol_device_fsm.sv
// protocol_device_fsm -- function-side USB-style protocol responder.
//
// Accepts IN/OUT tokens addressed to DEV_ADDR/DEV_ENDP, receives and
// handshakes OUT data, and sources IN data with retry on NAK or timeout.
// Every output is registered.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   pkt_received        decoder has a packet on pkt_in (1-cycle pulse)
//   crc_correct         CRC status, valid with pkt_received
//   pkt_in              decoded packet (pid, endp, addr, data)
//   pkt_sent            encoder finished transmitting (1-cycle pulse)
//   tx_data, tx_valid   IN payload from the device core and its ready flag
//   tx_taken            IN payload acknowledged by host (pulse)
//   rx_data, rx_valid   last good OUT payload and its update pulse
//   pkt_out, crc_type   packet to the encoder; 0 = handshake, 16 = data
//   encode, kill        start the encoder / abort the previous stream (pulses)
//   decode              arm the decoder (pulse)
//   success, failure    transaction-end pulses
package protocol_device_pkg;
  typedef struct packed {
    logic [3:0]  pid;
    logic [3:0]  endp;
    logic [6:0]  addr;
    logic [63:0] data;
  } pkt_t;

  localparam logic [3:0] PID_OUT  = 4'b0001;
  localparam logic [3:0] PID_IN   = 4'b1001;
  localparam logic [3:0] PID_DATA = 4'b0011;
  localparam logic [3:0] PID_ACK  = 4'b0010;
  localparam logic [3:0] PID_NAK  = 4'b1010;
endpackage

module protocol_device_fsm
  import protocol_device_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'd5,
  parameter logic [3:0] DEV_ENDP  = 4'd4,
  parameter logic [7:0] TIMEOUT   = 8'd255,
  parameter logic [3:0] MAX_RETRY = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_received,
  input  logic        crc_correct,
  input  pkt_t        pkt_in,
  input  logic        pkt_sent,
  input  logic [63:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_taken,
  output logic [63:0] rx_data,
  output logic        rx_valid,
  output pkt_t        pkt_out,
  output logic [4:0]  crc_type,
  output logic        encode,
  output logic        kill,
  output logic        decode,
  output logic        success,
  output logic        failure
);

  typedef enum logic [2:0] {IDLE, OUT_DATA, HS_TX, IN_TX, IN_ACK} state_t;

  state_t      state, state_n, ret_state, ret_state_n;
  logic [7:0]  clk_cnt, clk_cnt_n;
  logic [3:0]  corrupt_cnt, corrupt_cnt_n, tmo_cnt, tmo_cnt_n;
  logic        pend_succ, pend_succ_n;
  logic        boot, boot_n;
  pkt_t        pkt_out_n;
  logic [4:0]  crc_type_n;
  logic [63:0] rx_data_n;
  logic        tx_taken_n, rx_valid_n, encode_n, kill_n, decode_n, success_n, failure_n;
  logic        abort, token_ok;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= MAX_RETRY) ? MAX_RETRY : c + 4'd1;
  endfunction

  // Handshakes keep the previous data field; only pid/addr/endp change.
  function automatic pkt_t hs_pkt(input pkt_t cur, input logic [3:0] pid);
    pkt_t r;
    r      = cur;
    r.pid  = pid;
    r.addr = DEV_ADDR;
    r.endp = DEV_ENDP;
    return r;
  endfunction

  function automatic pkt_t data_pkt(input logic [63:0] d);
    pkt_t r;
    r.pid  = PID_DATA;
    r.addr = DEV_ADDR;
    r.endp = DEV_ENDP;
    r.data = d;
    return r;
  endfunction

  assign abort    = (corrupt_cnt == MAX_RETRY) || (tmo_cnt == MAX_RETRY);
  assign token_ok = crc_correct && (pkt_in.addr == DEV_ADDR) && (pkt_in.endp == DEV_ENDP);

  always_comb begin
    state_n       = state;
    ret_state_n   = ret_state;
    clk_cnt_n     = clk_cnt;
    corrupt_cnt_n = corrupt_cnt;
    tmo_cnt_n     = tmo_cnt;
    pend_succ_n   = pend_succ;
    boot_n        = 1'b0;
    pkt_out_n     = pkt_out;
    crc_type_n    = crc_type;
    rx_data_n     = rx_data;
    tx_taken_n    = 1'b0;
    rx_valid_n    = 1'b0;
    encode_n      = 1'b0;
    kill_n        = 1'b0;
    decode_n      = boot;   // arm the decoder once on leaving reset
    success_n     = 1'b0;
    failure_n     = 1'b0;

    case (state)
      IDLE: begin
        clk_cnt_n     = 8'd0;
        corrupt_cnt_n = 4'd0;
        tmo_cnt_n     = 4'd0;
        pend_succ_n   = 1'b0;
        if (pkt_received) begin
          if (token_ok && pkt_in.pid == PID_OUT) begin
            state_n  = OUT_DATA;
            decode_n = 1'b1;
          end else if (token_ok && pkt_in.pid == PID_IN) begin
            encode_n = 1'b1;
            kill_n   = 1'b1;
            if (tx_valid) begin
              pkt_out_n  = data_pkt(tx_data);
              crc_type_n = 5'd16;
              state_n    = IN_TX;
            end else begin
              pkt_out_n   = hs_pkt(pkt_out, PID_NAK);
              crc_type_n  = 5'd0;
              ret_state_n = IDLE;
              state_n     = HS_TX;
            end
          end else begin
            decode_n = 1'b1;
          end
        end
      end

      OUT_DATA: begin
        if (abort) begin
          failure_n = 1'b1;
          state_n   = IDLE;
        end else if (pkt_received) begin
          encode_n   = 1'b1;
          kill_n     = 1'b1;
          crc_type_n = 5'd0;
          state_n    = HS_TX;
          if (pkt_in.pid == PID_DATA && crc_correct) begin
            rx_data_n   = pkt_in.data;
            rx_valid_n  = 1'b1;
            pkt_out_n   = hs_pkt(pkt_out, PID_ACK);
            ret_state_n = IDLE;
            pend_succ_n = 1'b1;
          end else begin
            corrupt_cnt_n = sat_inc(corrupt_cnt);
            pkt_out_n     = hs_pkt(pkt_out, PID_NAK);
            ret_state_n   = OUT_DATA;
          end
        end else if (clk_cnt == TIMEOUT) begin
          tmo_cnt_n = sat_inc(tmo_cnt);
          clk_cnt_n = 8'd0;
          decode_n  = 1'b1;
        end else begin
          clk_cnt_n = clk_cnt + 8'd1;
        end
      end

      HS_TX: begin
        if (pkt_sent) begin
          state_n     = ret_state;
          success_n   = pend_succ;
          pend_succ_n = 1'b0;
          if (ret_state == OUT_DATA) begin
            decode_n  = 1'b1;
            clk_cnt_n = 8'd0;
          end
        end
      end

      IN_TX: begin
        if (pkt_sent) begin
          state_n   = IN_ACK;
          decode_n  = 1'b1;
          clk_cnt_n = 8'd0;
        end
      end

      IN_ACK: begin
        if (abort) begin
          failure_n = 1'b1;
          state_n   = IDLE;
        end else if (pkt_received) begin
          if (pkt_in.pid == PID_ACK && crc_correct) begin
            success_n  = 1'b1;
            tx_taken_n = 1'b1;
            state_n    = IDLE;
          end else begin
            // Any other reply (NAK, bad CRC) counts as a corrupted round.
            corrupt_cnt_n = sat_inc(corrupt_cnt);
            pkt_out_n     = data_pkt(tx_data);
            crc_type_n    = 5'd16;
            encode_n      = 1'b1;
            kill_n        = 1'b1;
            state_n       = IN_TX;
          end
        end else if (clk_cnt == TIMEOUT) begin
          tmo_cnt_n  = sat_inc(tmo_cnt);
          pkt_out_n  = data_pkt(tx_data);
          crc_type_n = 5'd16;
          encode_n   = 1'b1;
          kill_n     = 1'b1;
          state_n    = IN_TX;
        end else begin
          clk_cnt_n = clk_cnt + 8'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ret_state   <= IDLE;
      clk_cnt     <= 8'd0;
      corrupt_cnt <= 4'd0;
      tmo_cnt     <= 4'd0;
      pend_succ   <= 1'b0;
      boot        <= 1'b1;
      pkt_out     <= '0;
      crc_type    <= 5'd0;
      rx_data     <= 64'd0;
      tx_taken    <= 1'b0;
      rx_valid    <= 1'b0;
      encode      <= 1'b0;
      kill        <= 1'b0;
      decode      <= 1'b0;
      success     <= 1'b0;
      failure     <= 1'b0;
    end else begin
      state       <= state_n;
      ret_state   <= ret_state_n;
      clk_cnt     <= clk_cnt_n;
      corrupt_cnt <= corrupt_cnt_n;
      tmo_cnt     <= tmo_cnt_n;
      pend_succ   <= pend_succ_n;
      boot        <= boot_n;
      pkt_out     <= pkt_out_n;
      crc_type    <= crc_type_n;
      rx_data     <= rx_data_n;
      tx_taken    <= tx_taken_n;
      rx_valid    <= rx_valid_n;
      encode      <= encode_n;
      kill        <= kill_n;
      decode      <= decode_n;
      success     <= success_n;
      failure     <= failure_n;
    end
  end

endmodule

// File: tb/tb_protocol_device_fsm.sv
module tb_protocol_device_fsm;
  import protocol_device_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_received, crc_correct, pkt_sent, tx_valid;
  pkt_t        pkt_in;
  logic [63:0] tx_data;
  logic        tx_taken, rx_valid, encode, kill, decode, success, failure;
  logic [63:0] rx_data;
  pkt_t        pkt_out;
  logic [4:0]  crc_type;

  int errors = 0;
  int checks = 0;

  protocol_device_fsm dut (
    .clk(clk), .rst(rst), .pkt_received(pkt_received), .crc_correct(crc_correct),
    .pkt_in(pkt_in), .pkt_sent(pkt_sent), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_taken(tx_taken), .rx_data(rx_data), .rx_valid(rx_valid), .pkt_out(pkt_out),
    .crc_type(crc_type), .encode(encode), .kill(kill), .decode(decode),
    .success(success), .failure(failure)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                          input logic [63:0] data, input logic crc);
    pkt_in.pid   = pid;
    pkt_in.addr  = addr;
    pkt_in.endp  = endp;
    pkt_in.data  = data;
    crc_correct  = crc;
    pkt_received = 1'b1;
    tick();
    pkt_received = 1'b0;
  endtask

  task automatic pulse_sent();
    pkt_sent = 1'b1;
    tick();
    pkt_sent = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (pkt_out !== '0) begin errors++; $display("FAIL reset_pkt_out got %h want 0", pkt_out); end
    checks++; if ({encode, kill, decode, success, failure, rx_valid, tx_taken} !== 7'd0) begin
      errors++; $display("FAIL reset_pulses got %b want 0", {encode, kill, decode, success, failure, rx_valid, tx_taken}); end
    checks++; if (crc_type !== 5'd0 || rx_data !== 64'd0) begin
      errors++; $display("FAIL reset_regs got crc=%0d rx=%h want 0", crc_type, rx_data); end
    rst = 1'b0;
    tick();
    checks++; if (decode !== 1'b1) begin errors++; $display("FAIL reset_exit_decode got %b want 1", decode); end
    tick();
    checks++; if (decode !== 1'b0) begin errors++; $display("FAIL reset_decode_width got %b want 0", decode); end
  endtask

  task automatic test_out();
    send_pkt(PID_OUT, 7'd5, 4'd4, 64'd0, 1'b1);
    checks++; if (decode !== 1'b1 || encode !== 1'b0) begin
      errors++; $display("FAIL out_token got dec=%b enc=%b want 1 0", decode, encode); end
    send_pkt(PID_DATA, 7'd0, 4'd0, 64'hDEAD_BEEF_0123_4567, 1'b1);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 64'hDEAD_BEEF_0123_4567) begin
      errors++; $display("FAIL out_rx got v=%b d=%h want 1 deadbeef01234567", rx_valid, rx_data); end
    checks++; if (encode !== 1'b1 || kill !== 1'b1 || pkt_out.pid !== PID_ACK || crc_type !== 5'd0) begin
      errors++; $display("FAIL out_ack got enc=%b kill=%b pid=%b crc=%0d want 1 1 0010 0", encode, kill, pkt_out.pid, crc_type); end
    checks++; if (pkt_out.addr !== 7'd5 || pkt_out.endp !== 4'd4 || pkt_out.data !== 64'd0) begin
      errors++; $display("FAIL out_ack_fields got a=%0d e=%0d d=%h want 5 4 0", pkt_out.addr, pkt_out.endp, pkt_out.data); end
    checks++; if (success !== 1'b0) begin errors++; $display("FAIL out_early_success got %b want 0", success); end
    tick();
    checks++; if (rx_valid !== 1'b0 || encode !== 1'b0) begin
      errors++; $display("FAIL out_pulse_width got v=%b enc=%b want 0 0", rx_valid, encode); end
    pulse_sent();
    checks++; if (success !== 1'b1) begin errors++; $display("FAIL out_success got %b want 1", success); end
    tick();
    checks++; if (success !== 1'b0 || dut.state !== 3'd0) begin
      errors++; $display("FAIL out_idle got succ=%b state=%0d want 0 0", success, dut.state); end
  endtask

  task automatic test_in();
    tx_data  = 64'h1122334455667788;
    tx_valid = 1'b1;
    send_pkt(PID_IN, 7'd5, 4'd4, 64'd0, 1'b1);
    checks++; if (encode !== 1'b1 || pkt_out.pid !== PID_DATA || crc_type !== 5'd16 || pkt_out.data !== 64'h1122334455667788) begin
      errors++; $display("FAIL in_data got enc=%b pid=%b crc=%0d d=%h want 1 0011 16 1122334455667788", encode, pkt_out.pid, crc_type, pkt_out.data); end
    tick();
    pulse_sent();
    checks++; if (decode !== 1'b1) begin errors++; $display("FAIL in_arm got %b want 1", decode); end
    tick();
    send_pkt(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b1);
    checks++; if (success !== 1'b1 || tx_taken !== 1'b1) begin
      errors++; $display("FAIL in_done got succ=%b taken=%b want 1 1", success, tx_taken); end
    tick();
    checks++; if (success !== 1'b0 || tx_taken !== 1'b0 || dut.state !== 3'd0) begin
      errors++; $display("FAIL in_idle got succ=%b taken=%b state=%0d want 0 0 0", success, tx_taken, dut.state); end
  endtask

  task automatic test_in_nak();
    tx_valid = 1'b0;
    send_pkt(PID_IN, 7'd5, 4'd4, 64'd0, 1'b1);
    checks++; if (encode !== 1'b1 || pkt_out.pid !== PID_NAK || crc_type !== 5'd0 || pkt_out.data !== 64'h1122334455667788) begin
      errors++; $display("FAIL nak_tx got enc=%b pid=%b crc=%0d d=%h want 1 1010 0 1122334455667788", encode, pkt_out.pid, crc_type, pkt_out.data); end
    pulse_sent();
    checks++; if (success !== 1'b0 || dut.state !== 3'd0) begin
      errors++; $display("FAIL nak_idle got succ=%b state=%0d want 0 0", success, dut.state); end
    tick();
  endtask

  task automatic test_corrupt();
    send_pkt(PID_OUT, 7'd5, 4'd4, 64'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      send_pkt(PID_DATA, 7'd0, 4'd0, 64'h0BAD, 1'b0);
      checks++; if (encode !== 1'b1 || pkt_out.pid !== PID_NAK || rx_valid !== 1'b0 || rx_data !== 64'hDEAD_BEEF_0123_4567) begin
        errors++; $display("FAIL corrupt_nak%0d got enc=%b pid=%b v=%b d=%h", i, encode, pkt_out.pid, rx_valid, rx_data); end
      pulse_sent();
      checks++; if (decode !== 1'b1) begin errors++; $display("FAIL corrupt_rearm%0d got %b want 1", i, decode); end
    end
    checks++; if (dut.corrupt_cnt !== 4'd2) begin errors++; $display("FAIL corrupt_cnt got %0d want 2", dut.corrupt_cnt); end
    send_pkt(PID_DATA, 7'd0, 4'd0, 64'hAA55, 1'b1);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 64'hAA55 || pkt_out.pid !== PID_ACK) begin
      errors++; $display("FAIL corrupt_good got v=%b d=%h pid=%b want 1 aa55 0010", rx_valid, rx_data, pkt_out.pid); end
    pulse_sent();
    checks++; if (success !== 1'b1) begin errors++; $display("FAIL corrupt_success got %b want 1", success); end
    tick();
  endtask

  task automatic test_timeout();
    int resends = 0, n = 0, first_gap = 0;
    logic got_fail = 1'b0;
    tx_data  = 64'hCAFE;
    tx_valid = 1'b1;
    send_pkt(PID_IN, 7'd5, 4'd4, 64'd0, 1'b1);
    pulse_sent();
    for (int c = 0; c < 4000 && !got_fail; c++) begin
      tick();
      n++;
      if (encode) begin
        resends++;
        if (resends == 1) begin
          first_gap = n;
          checks++; if (pkt_out.data !== 64'hCAFE || crc_type !== 5'd16 || pkt_out.pid !== PID_DATA) begin
            errors++; $display("FAIL tmo_resend got d=%h crc=%0d pid=%b want cafe 16 0011", pkt_out.data, crc_type, pkt_out.pid); end
        end
        pulse_sent();
        n = 0;
      end else if (failure) begin
        got_fail = 1'b1;
      end
    end
    checks++; if (first_gap !== 256) begin errors++; $display("FAIL tmo_gap got %0d want 256", first_gap); end
    checks++; if (resends !== 8 || got_fail !== 1'b1) begin
      errors++; $display("FAIL tmo_abort got resends=%0d fail=%b want 8 1", resends, got_fail); end
    tick();
    checks++; if (failure !== 1'b0 || dut.state !== 3'd0) begin
      errors++; $display("FAIL tmo_idle got fail=%b state=%0d want 0 0", failure, dut.state); end
  endtask

  task automatic test_ignore();
    send_pkt(PID_IN, 7'd3, 4'd4, 64'd0, 1'b1);
    checks++; if (encode !== 1'b0 || decode !== 1'b1 || dut.state !== 3'd0) begin
      errors++; $display("FAIL ign_addr got enc=%b dec=%b state=%0d want 0 1 0", encode, decode, dut.state); end
    send_pkt(PID_OUT, 7'd5, 4'd4, 64'd0, 1'b0);
    checks++; if (encode !== 1'b0 || decode !== 1'b1 || dut.state !== 3'd0) begin
      errors++; $display("FAIL ign_crc got enc=%b dec=%b state=%0d want 0 1 0", encode, decode, dut.state); end
    tick();
  endtask

  task automatic test_rst_in_ack();
    tx_valid = 1'b1;
    send_pkt(PID_IN, 7'd5, 4'd4, 64'd0, 1'b1);
    pulse_sent();
    checks++; if (dut.state !== 3'd4) begin errors++; $display("FAIL rst_setup got state=%0d want 4", dut.state); end
    rst = 1'b1;
    tick();
    checks++; if (dut.state !== 3'd0 || pkt_out !== '0 || crc_type !== 5'd0 || rx_data !== 64'd0) begin
      errors++; $display("FAIL rst_mid got state=%0d crc=%0d rx=%h want 0 0 0", dut.state, crc_type, rx_data); end
    checks++; if ({encode, kill, decode, success, failure, rx_valid, tx_taken} !== 7'd0) begin
      errors++; $display("FAIL rst_mid_pulses got %b want 0", {encode, kill, decode, success, failure, rx_valid, tx_taken}); end
    rst = 1'b0;
    tick();
    checks++; if (decode !== 1'b1 || success !== 1'b0 || failure !== 1'b0) begin
      errors++; $display("FAIL rst_exit got dec=%b succ=%b fail=%b want 1 0 0", decode, success, failure); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    pkt_received = 1'b0;
    crc_correct  = 1'b0;
    pkt_sent     = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 64'd0;
    pkt_in       = '0;
    test_reset();
    test_out();
    test_in();
    test_in_nak();
    test_corrupt();
    test_timeout();
    test_ignore();
    test_rst_in_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
